// File: rtl/instr_fetch_unit_if.sv
// Signal bundle between the fetch unit, the instruction memory and decode.
// The master side is the fetch unit itself.
interface instr_fetch_unit_if #(
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   IM_Address;
   logic [31:0]   IM_Instruction;
   logic          Redirect;
   logic [31:0]   RedirectTarget;
   logic          OutValid;
   logic          OutReady;
   logic [31:0]   OutInstruction;
   logic [31:0]   OutPC;
   logic [31:0]   OutPCPlus4;
   logic          Fault;
   logic [CW-1:0] Count;

   modport master (
      output IM_Address, OutValid, OutInstruction, OutPC, OutPCPlus4, Fault, Count,
      input  IM_Instruction, Redirect, RedirectTarget, OutReady
   );

   modport slave (
      input  IM_Address, OutValid, OutInstruction, OutPC, OutPCPlus4, Fault, Count,
      output IM_Instruction, Redirect, RedirectTarget, OutReady
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Pipeline front end: owns the PC, fetches from combinational instruction memory
// and buffers {pc, instruction} pairs in a small FIFO towards decode.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          DEPTH      = 2,
   parameter logic [31:0] ADDR_LIMIT = 32'd4100
) (
   input logic               Clk,
   input logic               Reset,
   instr_fetch_unit_if.master bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [31:0]   pc_r;
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [31:0]   mem_instr_r [DEPTH];
   logic [31:0]   mem_pc_r    [DEPTH];
   logic [31:0]   last_instr_r;
   logic [31:0]   last_pc_r;

   logic          valid_s;
   logic          pop_s;
   logic          can_push_s;
   logic          fault_s;
   logic          fetch_s;
   logic [CW-1:0] count_next_s;
   logic [31:0]   head_instr_s;
   logic [31:0]   head_pc_s;

   assign valid_s    = (count_r != {CW{1'b0}});
   assign pop_s      = valid_s & bus.OutReady;
   assign can_push_s = (count_r < DEPTH_C) | pop_s;
   assign fault_s    = (pc_r >= ADDR_LIMIT);
   assign fetch_s    = ~bus.Redirect & ~fault_s & can_push_s;

   // Occupancy update for the non-flush case.
   always_comb begin
      count_next_s = count_r;
      case ({fetch_s, pop_s})
         2'b10:   count_next_s = count_r + CW'(1);
         2'b01:   count_next_s = count_r - CW'(1);
         default: count_next_s = count_r;
      endcase
   end

   // An empty FIFO keeps showing the last popped entry (or reset values).
   always_comb begin
      head_instr_s = last_instr_r;
      head_pc_s    = last_pc_r;
      if (valid_s) begin
         head_instr_s = mem_instr_r[rd_ptr_r];
         head_pc_s    = mem_pc_r[rd_ptr_r];
      end else begin
         head_instr_s = last_instr_r;
         head_pc_s    = last_pc_r;
      end
   end

   // PC, pointers and occupancy; reset outranks redirect, which outranks fetch/pop.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc_r         <= {RESET_PC[31:2], 2'b00};
         wr_ptr_r     <= {PW{1'b0}};
         rd_ptr_r     <= {PW{1'b0}};
         count_r      <= {CW{1'b0}};
         last_instr_r <= 32'h0000_0000;
         last_pc_r    <= 32'h0000_0000;
      end else if (bus.Redirect) begin
         pc_r     <= {bus.RedirectTarget[31:2], 2'b00};
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         count_r <= count_next_s;
         if (fetch_s) begin
            pc_r     <= pc_r + 32'd4;
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r     <= rd_ptr_r + PW'(1);
            last_instr_r <= head_instr_s;
            last_pc_r    <= head_pc_s;
         end
      end
   end

   // FIFO storage; entries are only readable while counted, so no reset needed.
   always_ff @(posedge Clk) begin
      if (!Reset && fetch_s) begin
         mem_instr_r[wr_ptr_r] <= bus.IM_Instruction;
         mem_pc_r[wr_ptr_r]    <= pc_r;
      end
   end

   assign bus.IM_Address     = pc_r;
   assign bus.OutValid       = valid_s;
   assign bus.OutInstruction = head_instr_s;
   assign bus.OutPC          = head_pc_s;
   assign bus.OutPCPlus4     = head_pc_s + 32'd4;
   assign bus.Fault          = fault_s;
   assign bus.Count          = count_r;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a main instance starting at PC 0 and a
// second instance starting near the end of instruction memory.
module tb_instr_fetch_unit;
   logic Clk;
   logic Reset;
   int   checks;
   int   errors;

   instr_fetch_unit_if #(.DEPTH(2)) bus ();
   instr_fetch_unit_if #(.DEPTH(2)) lbus ();

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2), .ADDR_LIMIT(32'd4100)) dut (
      .Clk(Clk), .Reset(Reset), .bus(bus.master)
   );
   instr_fetch_unit #(.RESET_PC(32'd4092), .DEPTH(2), .ADDR_LIMIT(32'd4100)) dut_lim (
      .Clk(Clk), .Reset(Reset), .bus(lbus.master)
   );

   // Memory model: word[k] = 0x1000_0000 + k
   assign bus.IM_Instruction  = 32'h1000_0000 + (bus.IM_Address >> 2);
   assign lbus.IM_Instruction = 32'h1000_0000 + (lbus.IM_Address >> 2);

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      step();
      step();
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      bus.OutReady = 1'b1;
      do_reset();
      chk("reset_valid", {31'd0, bus.OutValid}, 32'd0);
      chk("reset_instr", bus.OutInstruction, 32'd0);
      chk("reset_pc", bus.OutPC, 32'd0);
      chk("reset_pc4", bus.OutPCPlus4, 32'd4);
      chk("reset_fault", {31'd0, bus.Fault}, 32'd0);
      chk("reset_count", {30'd0, bus.Count}, 32'd0);
      chk("reset_addr", bus.IM_Address, 32'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("stream_valid", {31'd0, bus.OutValid}, 32'd1);
         chk("stream_instr", bus.OutInstruction, 32'h1000_0000 + k);
         chk("stream_pc", bus.OutPC, 32'(4 * k));
         chk("stream_pc4", bus.OutPCPlus4, 32'(4 * k + 4));
         chk("stream_addr", bus.IM_Address, 32'(4 * k + 4));
      end
   endtask

   task automatic test_backpressure();
      bus.OutReady = 1'b0;
      do_reset();
      for (int k = 0; k < 4; k++) step();
      chk("bp_count", {30'd0, bus.Count}, 32'd2);
      chk("bp_addr", bus.IM_Address, 32'd8);
      chk("bp_head_pc", bus.OutPC, 32'd0);
      chk("bp_head_instr", bus.OutInstruction, 32'h1000_0000);
   endtask

   task automatic test_full_and_pop();
      bus.OutReady = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("full_pop_count", {30'd0, bus.Count}, 32'd2);
         chk("full_pop_head_pc", bus.OutPC, 32'(4 * k));
         chk("full_pop_instr", bus.OutInstruction, 32'h1000_0000 + k);
         chk("full_pop_addr", bus.IM_Address, 32'(8 + 4 * k));
      end
   endtask

   task automatic test_redirect();
      bus.Redirect       = 1'b1;
      bus.RedirectTarget = 32'h0000_0103;
      step();
      bus.Redirect = 1'b0;
      chk("redir_valid", {31'd0, bus.OutValid}, 32'd0);
      chk("redir_count", {30'd0, bus.Count}, 32'd0);
      chk("redir_addr", bus.IM_Address, 32'h0000_0100);
      step();
      chk("redir_valid2", {31'd0, bus.OutValid}, 32'd1);
      chk("redir_pc", bus.OutPC, 32'h0000_0100);
      chk("redir_instr", bus.OutInstruction, 32'h1000_0040);
      chk("redir_pc4", bus.OutPCPlus4, 32'h0000_0104);
   endtask

   task automatic test_addr_limit();
      lbus.OutReady = 1'b0;
      do_reset();
      chk("lim_fault0", {31'd0, lbus.Fault}, 32'd0);
      chk("lim_addr0", lbus.IM_Address, 32'd4092);
      step();
      chk("lim_pc_a", lbus.OutPC, 32'd4092);
      chk("lim_pc4_a", lbus.OutPCPlus4, 32'd4096);
      step();
      chk("lim_fault1", {31'd0, lbus.Fault}, 32'd1);
      chk("lim_addr1", lbus.IM_Address, 32'd4100);
      lbus.OutReady = 1'b1;
      step();
      chk("lim_drain_count", {30'd0, lbus.Count}, 32'd1);
      chk("lim_drain_pc", lbus.OutPC, 32'd4096);
      chk("lim_drain_instr", lbus.OutInstruction, 32'h1000_0400);
      chk("lim_hold_addr", lbus.IM_Address, 32'd4100);
      step();
      chk("lim_empty_valid", {31'd0, lbus.OutValid}, 32'd0);
      chk("lim_still_fault", {31'd0, lbus.Fault}, 32'd1);
      chk("lim_hold_addr2", lbus.IM_Address, 32'd4100);
      lbus.Redirect       = 1'b1;
      lbus.RedirectTarget = 32'h0000_0000;
      step();
      lbus.Redirect = 1'b0;
      chk("lim_clear_fault", {31'd0, lbus.Fault}, 32'd0);
      chk("lim_clear_addr", lbus.IM_Address, 32'd0);
      step();
      chk("lim_resume_valid", {31'd0, lbus.OutValid}, 32'd1);
      chk("lim_resume_pc", lbus.OutPC, 32'd0);
      chk("lim_resume_addr", lbus.IM_Address, 32'd4);
   endtask

   task automatic test_mid_reset();
      bus.OutReady = 1'b1;
      do_reset();
      for (int k = 0; k < 16; k++) step();
      chk("mid_pre_count", {30'd0, bus.Count}, 32'd1);
      chk("mid_pre_addr", bus.IM_Address, 32'h0000_0040);
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      chk("mid_valid", {31'd0, bus.OutValid}, 32'd0);
      chk("mid_count", {30'd0, bus.Count}, 32'd0);
      chk("mid_addr", bus.IM_Address, 32'd0);
      chk("mid_instr", bus.OutInstruction, 32'd0);
      chk("mid_pc4", bus.OutPCPlus4, 32'd4);
   endtask

   initial begin
      checks              = 0;
      errors              = 0;
      Reset               = 1'b1;
      bus.Redirect        = 1'b0;
      bus.RedirectTarget  = 32'h0000_0000;
      bus.OutReady        = 1'b0;
      lbus.Redirect       = 1'b0;
      lbus.RedirectTarget = 32'h0000_0000;
      lbus.OutReady       = 1'b0;
      test_reset();
      test_backpressure();
      test_full_and_pop();
      test_redirect();
      test_addr_limit();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the pipeline: owns the PC, drives word addresses into the combinational instruction memory and captures the returned instruction words.
- Buffers fetched words in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects (FIFO flush) and stops fetching at the end of the instruction-memory range.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, FIFO entries. Power of 2, minimum 2.
- ADDR_LIMIT, 32'd4100, first byte address not backed by instruction memory (1025 words × 4).

Ports:
- Clk  input  1  clock. All state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- IM_Address  output  32  byte address to instruction memory. Always equals the PC register.
- IM_Instruction  input  32  word returned combinationally for IM_Address in the same cycle.
- Redirect  input  1  one-cycle pulse: flush and restart fetch at RedirectTarget.
- RedirectTarget  input  32  new PC. Bits [1:0] are ignored (forced to 0).
- OutValid  output  1  FIFO head holds a valid instruction.
- OutReady  input  1  decode accepts the head this cycle.
- OutInstruction  output  32  instruction word at the FIFO head.
- OutPC  output  32  address of the head instruction.
- OutPCPlus4  output  32  OutPC + 4, modulo 2^32.
- Fault  output  1  PC >= ADDR_LIMIT; fetching is suspended.
- Count  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, highest priority):
  - PC <= RESET_PC; FIFO pointers and Count <= 0.
  - After reset: OutValid = 0, OutInstruction = 0, OutPC = 0, OutPCPlus4 = 4, Fault = (RESET_PC >= ADDR_LIMIT).
  - Reset asserted mid-stream discards all buffered entries in that cycle.
- Definitions, evaluated each cycle:
  - pop = OutValid & OutReady.
  - can_push = (Count < DEPTH) | pop.
  - fetch = ~Redirect & ~Fault & can_push.
- Fetch, when fetch = 1:
  - Push {PC, IM_Instruction} at the tail.
  - PC <= PC + 4.
- When fetch = 0 (and no Redirect), PC holds.
- Latency: a word addressed in cycle N is presented on OutValid in cycle N+1 at the earliest. Sustained throughput is 1 instruction/cycle while OutReady = 1.
- FIFO:
  - Registered storage. Outputs come directly from the head entry.
  - When empty, the outputs show the last popped entry's fields or the reset values, with OutValid = 0.
  - Pointers wrap modulo DEPTH.
  - Full plus pop in the same cycle: push and pop both occur, Count is unchanged.
  - Empty: no pop is possible. A push into an empty FIFO becomes visible the next cycle; there is no same-cycle bypass.
- Redirect (priority below Reset):
  - FIFO flushed: Count <= 0, pointers <= 0.
  - PC <= {RedirectTarget[31:2], 2'b00}.
  - No push that cycle, and IM_Instruction is discarded.
  - A simultaneous pop is discarded; decode must treat that handshake as void.
  - OutValid = 0 in the cycle after the redirect. The first target instruction is visible two cycles after the redirect.
- Fault:
  - Combinational: Fault = (PC >= ADDR_LIMIT).
  - While Fault = 1: no pushes, PC holds, and already-buffered entries still drain normally.
  - Cleared only by a Redirect to an in-range target, or by Reset.
- Arithmetic:
  - All PC arithmetic is 32-bit unsigned with wrap.
  - PC[1:0] is always 0.
  - The ADDR_LIMIT compare is unsigned.
- IM_Address is a registered output, glitch-free. It changes only on Clk edges.

Test Plan:
- Reset held 2 cycles, then released with OutReady = 1, memory word[k] = 0x1000_0000 + k.
  - Required: IM_Address = 0, 4, 8, …
  - OutValid rises 1 cycle after release; OutInstruction = 0x1000_0000, 0x1000_0001, … on consecutive cycles.
  - OutPC = 0, 4, 8; OutPCPlus4 = 4, 8, 12.
- Backpressure: OutReady = 0 for 4 cycles from reset release.
  - Required: Count reaches 2 and PC stalls at 8.
  - On OutReady = 1: entries for PC 0 and 4 are delivered, then PC 8 follows with no gap and no duplication.
- Full and popping simultaneously (Count = 2, OutReady = 1).
  - Required: Count stays 2 and PC advances by 4 every cycle.
- Redirect with RedirectTarget = 0x0000_0103 while Count = 2 and OutReady = 1.
  - Required: next cycle OutValid = 0, Count = 0, IM_Address = 0x100.
  - Following cycle: OutPC = 0x100, OutInstruction = word[64].
- Address limit: RESET_PC = 4092 (ADDR_LIMIT = 4100).
  - Required: fetches for 4092 and 4096 occur, then Fault = 1 and PC holds at 4100; buffered entries still drain.
  - Redirect to 0 clears Fault the next cycle and fetch resumes.
- Reset asserted mid-stream (Count = 1, PC = 0x40).
  - Required: next cycle OutValid = 0, Count = 0, IM_Address = RESET_PC.
